// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: opcode values, the
// canonical quiet NaN returned on a watchdog abort, and the FSM states.
package fpu_issue_ctrl_pkg;

  localparam logic [1:0]  FPU_OP_ADD = 2'b00;
  localparam logic [1:0]  FPU_OP_MUL = 2'b01;
  localparam logic [31:0] FPU_QNAN   = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_START = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/fpu_issue_ctrl_watchdog.sv
// fpu_watchdog: counts cycles while enabled and flags expiry for a hung FPU.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - zero the counter and drop expire (held during CLEAR)
//   enable    - count this cycle (held during START)
//   expire    - registered; rises the cycle after the count reaches TIMEOUT-1
module fpu_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // Expire is registered, so the controller sees it one cycle after the
  // count hits TIMEOUT-1; counting stops once expired, so no wrap occurs.
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = expire_q;
    if (clear) begin
      cnt_d    = '0;
      expire_d = 1'b0;
    end else if (enable && !expire_q) begin
      cnt_d    = cnt_q + CNT_W'(1);
      expire_d = (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: initiator side of the FPU start/done handshake.
// Accepts one request at a time (req_*), pulses fpu_rst for one cycle,
// holds fpu_start with stable op/operands until fpu_done, then presents
// the captured result with its tag on the rsp_* port. A watchdog aborts
// a hung FPU and returns a canonical quiet NaN with rsp_timeout set.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   req_valid/ready/op/a/b/tag    - request channel (ready only in IDLE)
//   fpu_rst/start/op/a/b          - drive side of the FPU
//   fpu_r, fpu_done               - FPU result and completion (done used in START only)
//   rsp_valid/ready/result/tag/timeout - response channel
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             fpu_rst,
  output logic             fpu_start,
  output logic [1:0]       fpu_op,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  input  logic [WIDTH-1:0] fpu_r,
  input  logic             fpu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             timeout_q, timeout_d;
  logic             fpu_rst_q, fpu_rst_d;
  logic             fpu_start_q, fpu_start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             wd_expire;

  fpu_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == S_CLEAR),
    .enable(state_q == S_START),
    .expire(wd_expire)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          tag_d   = req_tag;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_START;
      S_START: begin
        // A completion in the same cycle as expiry still counts as done.
        if (fpu_done) begin
          result_d  = fpu_r;
          timeout_d = 1'b0;
          state_d   = S_RESP;
        end else if (wd_expire) begin
          result_d  = WIDTH'(FPU_QNAN);
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they align with it.
    fpu_rst_d   = (state_d == S_CLEAR);
    fpu_start_d = (state_d == S_START);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      result_q    <= '0;
      timeout_q   <= 1'b0;
      fpu_rst_q   <= 1'b0;
      fpu_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      result_q    <= result_d;
      timeout_q   <= timeout_d;
      fpu_rst_q   <= fpu_rst_d;
      fpu_start_q <= fpu_start_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // The FPU must be held in reset for as long as the controller is.
  assign fpu_rst     = rst | fpu_rst_q;
  assign req_ready   = (state_q == S_IDLE) & ~rst;
  assign fpu_start   = fpu_start_q;
  assign fpu_op      = op_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = result_q;
  assign rsp_tag     = tag_q;
  assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl with a behavioural FPU whose done
// latency N counts START cycles after a one-cycle clear on fpu_rst.
module tb_fpu_issue_ctrl;

  localparam int          TMO  = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        fpu_rst, fpu_start, fpu_done;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b, fpu_r;
  logic        rsp_valid, rsp_timeout;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Behavioural FPU: done in the START cycle where N START cycles have elapsed.
  int          m_cnt = 0;
  int          m_n = 0;
  logic        m_en = 1'b0;
  logic        m_stale = 1'b0;
  logic [31:0] m_r = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (fpu_rst) m_cnt <= 0;
    else if (fpu_start) m_cnt <= m_cnt + 1;
  end
  assign fpu_done = (m_en && fpu_start && m_cnt == m_n) || (m_stale && !fpu_start);
  assign fpu_r    = m_r;

  fpu_issue_ctrl #(.WIDTH(32), .TAG_W(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_rst(fpu_rst), .fpu_start(fpu_start), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_r(fpu_r), .fpu_done(fpu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout)
  );

  // Reference: response cycle relative to the accept edge, and abort flag.
  function automatic int exp_cycle(input logic en, input int n);
    if (en && n <= TMO) return 3 + n;
    return 3 + TMO;
  endfunction

  function automatic logic exp_tmo(input logic en, input int n);
    return !(en && n <= TMO);
  endfunction

  // Drives one request (caller is at a negedge) and observes it to completion.
  task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic en, input int n,
                         input logic [31:0] r, input int dly,
                         output int acc, output int rcyc, output logic [31:0] res,
                         output logic [4:0] rt, output logic tmo, output int err_stab,
                         output int err_seq, output int err_hold, output logic rdy_after);
    err_stab = 0; err_seq = 0; err_hold = 0; rcyc = -1; rdy_after = 1'b0;
    res = '0; rt = '0; tmo = 1'b0;
    m_en = en; m_n = n; m_r = r;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
    req_op = 2'($urandom); req_tag = 5'($urandom);
    for (int k = 1; k <= TMO + 20; k++) begin
      @(negedge clk);
      if (fpu_op !== op || fpu_a !== a || fpu_b !== b) err_stab++;
      if (rsp_valid === 1'b1) begin
        rcyc = k;
        if (fpu_start !== 1'b0 || fpu_rst !== 1'b0) err_seq++;
        break;
      end
      if (fpu_rst !== (k == 1) || fpu_start !== (k >= 2) || req_ready !== 1'b0) err_seq++;
    end
    if (rcyc < 0) return;
    res = rsp_result; rt = rsp_tag; tmo = rsp_timeout;
    req_valid = 1'b1;  // must not be accepted while a response is pending
    for (int d = 0; d < dly; d++) begin
      if (rsp_valid !== 1'b1 || rsp_result !== res || rsp_tag !== rt || rsp_timeout !== tmo ||
          req_ready !== 1'b0 || fpu_a !== a || fpu_b !== b || fpu_op !== op) err_hold++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) err_hold++;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    rdy_after = (req_ready === 1'b1) && (rsp_valid === 1'b0);
  endtask

  task automatic test_reset;
    #3;
    tests_run++;
    if ({req_ready, fpu_rst, fpu_start, rsp_valid} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got ready/rst/start/valid=%b expected 0100",
               {req_ready, fpu_rst, fpu_start, rsp_valid});
    end
    tests_run++;
    if ({fpu_op, fpu_a, fpu_b, rsp_result, rsp_tag, rsp_timeout} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got op=%h a=%h b=%h res=%h tag=%h tmo=%b expected all zero",
               fpu_op, fpu_a, fpu_b, rsp_result, rsp_tag, rsp_timeout);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || fpu_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got ready=%b fpu_rst=%b expected 1 0", req_ready, fpu_rst);
    end
    @(negedge clk);
  endtask

  task automatic test_add;
    int acc, rc, es, eq, eh; logic [31:0] res; logic [4:0] rt; logic tmo, ra;
    m_stale = 1'b0;
    run_txn(2'b00, 32'h41C0_0000, 32'h40C0_0000, 5'd5, 1'b1, 13, 32'h41F0_0000, 0,
            acc, rc, res, rt, tmo, es, eq, eh, ra);
    tests_run++;
    if (rc != exp_cycle(1'b1, 13)) begin
      tests_failed++; $display("FAIL add_latency: got %0d expected %0d", rc, exp_cycle(1'b1, 13));
    end
    tests_run++;
    if (res !== 32'h41F0_0000 || rt !== 5'd5 || tmo !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_result: got %h tag %0d tmo %b expected 41f00000 tag 5 tmo 0", res, rt, tmo);
    end
    tests_run++;
    if (es != 0 || eq != 0) begin
      tests_failed++; $display("FAIL add_sequence: got stab=%0d seq=%0d errors expected 0", es, eq);
    end
  endtask

  task automatic test_backpressure;
    int acc, rc, es, eq, eh; logic [31:0] res; logic [4:0] rt; logic tmo, ra;
    run_txn(2'b00, 32'h3FE0_0000, 32'h3F93_3333, 5'd17, 1'b1, 4, 32'h4039_999A, 4,
            acc, rc, res, rt, tmo, es, eq, eh, ra);
    tests_run++;
    if (res !== 32'h4039_999A || rt !== 5'd17) begin
      tests_failed++; $display("FAIL bp_result: got %h tag %0d expected 4039999a tag 17", res, rt);
    end
    tests_run++;
    if (eh != 0) begin
      tests_failed++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", eh);
    end
    tests_run++;
    if (ra !== 1'b1) begin
      tests_failed++; $display("FAIL bp_ready_after: got %b expected 1", ra);
    end
  endtask

  task automatic test_mul_long;
    int acc, rc, es, eq, eh; logic [31:0] res; logic [4:0] rt; logic tmo, ra;
    run_txn(2'b01, 32'h4056_5C86, 32'h3EC2_8F5C, 5'd9, 1'b1, 100, 32'h3FA2_B8C2, 1,
            acc, rc, res, rt, tmo, es, eq, eh, ra);
    tests_run++;
    if (es != 0 || eh != 0) begin
      tests_failed++; $display("FAIL mul_stable: got stab=%0d hold=%0d expected 0", es, eh);
    end
    tests_run++;
    if (res !== 32'h3FA2_B8C2 || rc != exp_cycle(1'b1, 100)) begin
      tests_failed++;
      $display("FAIL mul_result: got %h at %0d expected 3fa2b8c2 at %0d", res, rc, exp_cycle(1'b1, 100));
    end
  endtask

  task automatic test_timeout;
    int acc, rc, es, eq, eh; logic [31:0] res; logic [4:0] rt; logic tmo, ra;
    logic en_t[3] = '{1'b0, 1'b1, 1'b1};
    int   n_t[3]  = '{0, TMO, TMO + 1};
    for (int i = 0; i < 3; i++) begin
      run_txn(2'b10, $urandom, $urandom, 5'(i), en_t[i], n_t[i], 32'h1234_5678, 0,
              acc, rc, res, rt, tmo, es, eq, eh, ra);
      tests_run++;
      if (rc != exp_cycle(en_t[i], n_t[i])) begin
        tests_failed++;
        $display("FAIL timeout_latency[%0d]: got %0d expected %0d", i, rc, exp_cycle(en_t[i], n_t[i]));
      end
      tests_run++;
      if (tmo !== exp_tmo(en_t[i], n_t[i]) ||
          res !== (exp_tmo(en_t[i], n_t[i]) ? QNAN : 32'h1234_5678)) begin
        tests_failed++;
        $display("FAIL timeout_result[%0d]: got %h tmo %b expected tmo %b", i, res, tmo,
                 exp_tmo(en_t[i], n_t[i]));
      end
    end
  endtask

  task automatic test_stale_done;
    int acc, rc, es, eq, eh; logic [31:0] res; logic [4:0] rt; logic tmo, ra;
    m_stale = 1'b1;
    run_txn(2'b00, 32'h1, 32'h2, 5'd3, 1'b1, 5, 32'hCAFE_0005, 0,
            acc, rc, res, rt, tmo, es, eq, eh, ra);
    m_stale = 1'b0;
    tests_run++;
    if (rc != exp_cycle(1'b1, 5) || res !== 32'hCAFE_0005 || tmo !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_done: got cycle %0d res %h tmo %b expected cycle %0d res cafe0005 tmo 0",
               rc, res, tmo, exp_cycle(1'b1, 5));
    end
  endtask

  task automatic test_reset_midop;
    int acc, rc, es, eq, eh, bad; logic [31:0] res; logic [4:0] rt; logic tmo, ra;
    m_en = 1'b1; m_n = 20; m_r = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'h55; req_b = 32'h66; req_tag = 5'd21;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({req_ready, fpu_rst, fpu_start, rsp_valid} !== 4'b0100 ||
        {fpu_op, fpu_a, fpu_b, rsp_tag} !== '0) begin
      tests_failed++;
      $display("FAIL midop_reset: got ready/rst/start/valid=%b a=%h expected 0100 and zero data",
               {req_ready, fpu_rst, fpu_start, rsp_valid}, fpu_a);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || fpu_start !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL midop_quiet: got %0d active cycles expected 0", bad);
    end
    run_txn(2'b00, 32'h77, 32'h88, 5'd2, 1'b1, 7, 32'h0BAD_F00D, 0,
            acc, rc, res, rt, tmo, es, eq, eh, ra);
    tests_run++;
    if (rc != exp_cycle(1'b1, 7) || res !== 32'h0BAD_F00D || rt !== 5'd2) begin
      tests_failed++;
      $display("FAIL midop_recover: got cycle %0d res %h tag %0d expected %0d 0badf00d 2",
               rc, res, rt, exp_cycle(1'b1, 7));
    end
  endtask

  task automatic test_back_to_back;
    int acc1, acc2, rc, es, eq, eh; logic [31:0] res; logic [4:0] rt; logic tmo, ra;
    run_txn(2'b00, 32'h10, 32'h20, 5'd1, 1'b1, 3, 32'h30, 0, acc1, rc, res, rt, tmo, es, eq, eh, ra);
    run_txn(2'b01, 32'h11, 32'h21, 5'd2, 1'b1, 6, 32'h31, 0, acc2, rc, res, rt, tmo, es, eq, eh, ra);
    tests_run++;
    if (acc2 - acc1 != 3 + 4) begin
      tests_failed++; $display("FAIL b2b_spacing: got %0d cycles expected %0d", acc2 - acc1, 7);
    end
  endtask

  task automatic test_random;
    int acc, rc, es, eq, eh, n, dly; logic [31:0] res, a, b, r; logic [4:0] rt, tag;
    logic tmo, ra, en; logic [1:0] op;
    for (int i = 0; i < 24; i++) begin
      en = ($urandom_range(0, 9) != 0);
      n = (i % 8 == 7) ? int'($urandom_range(TMO - 2, TMO + 2)) : int'($urandom_range(0, 30));
      dly = $urandom_range(0, 3);
      a = $urandom; b = $urandom; r = $urandom; op = 2'($urandom); tag = 5'($urandom);
      m_stale = 1'($urandom);
      run_txn(op, a, b, tag, en, n, r, dly, acc, rc, res, rt, tmo, es, eq, eh, ra);
      m_stale = 1'b0;
      tests_run++;
      if (rc != exp_cycle(en, n) || res !== (exp_tmo(en, n) ? QNAN : r) ||
          tmo !== exp_tmo(en, n) || rt !== tag) begin
        tests_failed++;
        $display("FAIL rand[%0d]: got cycle %0d res %h tmo %b tag %0d expected %0d %h %b %0d", i,
                 rc, res, tmo, rt, exp_cycle(en, n), exp_tmo(en, n) ? QNAN : r, exp_tmo(en, n), tag);
      end
      tests_run++;
      if (es != 0 || eq != 0 || eh != 0 || ra !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand_proto[%0d]: got stab=%0d seq=%0d hold=%0d ready_after=%b expected 0 0 0 1",
                 i, es, eq, eh, ra);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_backpressure;
    test_mul_long;
    test_timeout;
    test_stale_done;
    test_reset_midop;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not complete, %0d failed so far", tests_failed);
    $fatal(1, "time limit");
  end

endmodule
